// File: rtl/lap_counter_gen_if.sv
// Control and status bundle for lap_counter_gen.
// The master drives requests, and the slave (the counter) returns the count state.
interface lap_counter_gen_if #(
    parameter int BUS_SIZE = 4,
    parameter int LAP_W    = 8
);
    logic                en;
    logic                nSet;
    logic                load;
    logic [BUS_SIZE-1:0] load_val;
    logic                up;
    logic                sat;
    logic [BUS_SIZE-1:0] S;
    logic                tc;
    logic                wrap;
    logic [LAP_W-1:0]    laps;
    logic                ovf;

    modport master (
        output en, nSet, load, load_val, up, sat,
        input  S, tc, wrap, laps, ovf
    );

    modport slave (
        input  en, nSet, load, load_val, up, sat,
        output S, tc, wrap, laps, ovf
    );
endinterface

// File: rtl/lap_counter_gen.sv
// Up/down modulo lap counter with load, preset, wrap/saturate mode,
// a registered wrap pulse for cascading, and a saturating lap counter.
module lap_counter_gen #(
    parameter int MODULO   = 10,
    parameter int BUS_SIZE = 4,
    parameter int LAP_W    = 8
) (
    input  logic               clk,
    input  logic               nReset,
    lap_counter_gen_if.slave   bus
);
    // The count is compared in BUS_SIZE+1 bits so that MODULO == 2^BUS_SIZE does not truncate.
    localparam int                 W       = BUS_SIZE + 1;
    localparam logic [W-1:0]        MOD_X   = W'(MODULO);
    localparam logic [W-1:0]        TOP_X   = W'(MODULO - 1);
    localparam logic [BUS_SIZE-1:0] TOP     = BUS_SIZE'(MODULO - 1);
    localparam logic [LAP_W-1:0]    LAP_MAX = '1;

    logic [W-1:0] s_x, lv_x, inc_x, dec_x;
    logic         hi_end, lo_end, oor;

    assign s_x    = {1'b0, bus.S};
    assign lv_x   = {1'b0, bus.load_val};
    assign inc_x  = s_x + W'(1);
    assign dec_x  = s_x - W'(1);
    assign oor    = (s_x >= MOD_X);
    assign hi_end = (s_x >= TOP_X);   // an out-of-range count behaves like the top value
    assign lo_end = (s_x == '0);

    assign bus.tc = (bus.up && (s_x == TOP_X)) || (!bus.up && lo_end);

    always_ff @(posedge clk) begin
        if (nReset) begin
            bus.S    <= '0;
            bus.laps <= '0;
            bus.wrap <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (bus.nSet) begin
            bus.S    <= TOP;
            bus.wrap <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (bus.load) begin
            bus.S    <= (lv_x < MOD_X) ? bus.load_val : TOP;
            bus.wrap <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (bus.en) begin
            bus.wrap <= 1'b0;
            if (bus.up) begin
                if (hi_end) begin
                    if (bus.sat) begin
                        bus.S   <= TOP;
                        bus.ovf <= 1'b1;
                    end else begin
                        bus.S    <= '0;
                        bus.wrap <= 1'b1;
                        if (bus.laps != LAP_MAX) bus.laps <= bus.laps + LAP_W'(1);
                    end
                end else begin
                    bus.S <= inc_x[BUS_SIZE-1:0];
                end
            end else begin
                if (lo_end) begin
                    if (bus.sat) begin
                        bus.ovf <= 1'b1;
                    end else begin
                        bus.S    <= TOP;
                        bus.wrap <= 1'b1;
                        if (bus.laps != '0) bus.laps <= bus.laps - LAP_W'(1);
                    end
                end else if (oor) begin
                    // Recovering from an upset on a down-count is not a lap.
                    bus.S <= TOP;
                end else begin
                    bus.S <= dec_x[BUS_SIZE-1:0];
                end
            end
        end else begin
            bus.wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lap_counter_gen.sv
// Self-checking bench for lap_counter_gen: directed table, corner sequences,
// cascading, wide-modulo and LAP_W=2 instances, and random stimulus against a reference model.
module tb_lap_counter_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    int   n_chk = 0;
    int   n_fail = 0;

    lap_counter_gen_if #(.BUS_SIZE(4), .LAP_W(8)) bus_a ();
    lap_counter_gen_if #(.BUS_SIZE(4), .LAP_W(2)) bus_b ();
    lap_counter_gen_if #(.BUS_SIZE(4), .LAP_W(8)) bus_lo ();
    lap_counter_gen_if #(.BUS_SIZE(4), .LAP_W(8)) bus_hi ();
    lap_counter_gen_if #(.BUS_SIZE(4), .LAP_W(8)) bus_d ();

    lap_counter_gen #(.MODULO(10), .BUS_SIZE(4), .LAP_W(8)) dut    (.clk(clk), .nReset(rst_a), .bus(bus_a));
    lap_counter_gen #(.MODULO(10), .BUS_SIZE(4), .LAP_W(2)) dut_l2 (.clk(clk), .nReset(rst_b), .bus(bus_b));
    lap_counter_gen #(.MODULO(10), .BUS_SIZE(4), .LAP_W(8)) dut_lo (.clk(clk), .nReset(rst_c), .bus(bus_lo));
    lap_counter_gen #(.MODULO(10), .BUS_SIZE(4), .LAP_W(8)) dut_hi (.clk(clk), .nReset(rst_c), .bus(bus_hi));
    lap_counter_gen #(.MODULO(16), .BUS_SIZE(4), .LAP_W(8)) dut_16 (.clk(clk), .nReset(rst_d), .bus(bus_d));

    assign bus_hi.en = bus_lo.wrap;

    typedef struct {
        logic rst, nset, ld;
        int   lv;
        logic en, up, sat;
        int   s;
        logic w;
        int   laps;
        logic ovf, tc;
    } vec_t;
    vec_t tbl [16];

    // Reference model of the M=10, LAP_W=8 counter.
    int m_s, m_laps, m_wrap, m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic rst, nset, ld, input int lv, input logic en, up, sat);
        rst_a = rst; bus_a.nSet = nset; bus_a.load = ld; bus_a.load_val = 4'(lv);
        bus_a.en = en; bus_a.up = up; bus_a.sat = sat;
    endtask

    task automatic model(input logic rst, nset, ld, input int lv, input logic en, up, sat);
        m_wrap = 0;
        if (rst) begin m_s = 0; m_laps = 0; m_ovf = 0; end
        else if (nset) begin m_s = 9; m_ovf = 0; end
        else if (ld) begin m_s = (lv < 10) ? lv : 9; m_ovf = 0; end
        else if (en) begin
            if (up) begin
                if (m_s == 9) begin
                    if (sat) m_ovf = 1;
                    else begin m_s = 0; m_wrap = 1; if (m_laps < 255) m_laps++; end
                end else m_s++;
            end else begin
                if (m_s == 0) begin
                    if (sat) m_ovf = 1;
                    else begin m_s = 9; m_wrap = 1; if (m_laps > 0) m_laps--; end
                end else m_s--;
            end
        end
    endtask

    initial begin
        int hi_wraps;
        drive_a(1, 0, 0, 0, 0, 1, 0);
        rst_b = 1; bus_b.nSet = 0; bus_b.load = 0; bus_b.load_val = 0; bus_b.en = 0; bus_b.up = 1; bus_b.sat = 0;
        rst_c = 1; bus_lo.nSet = 0; bus_lo.load = 0; bus_lo.load_val = 0; bus_lo.en = 0; bus_lo.up = 1; bus_lo.sat = 0;
        bus_hi.nSet = 0; bus_hi.load = 0; bus_hi.load_val = 0; bus_hi.up = 1; bus_hi.sat = 0;
        rst_d = 1; bus_d.nSet = 0; bus_d.load = 0; bus_d.load_val = 0; bus_d.en = 0; bus_d.up = 1; bus_d.sat = 0;

        //           rst nset ld lv en up sat   S  w laps ovf tc
        tbl[0]  = '{1, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 1, 7,  1, 1, 0,  0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 5,  1, 1, 0,  9, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 1, 12, 0, 1, 0,  9, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 1, 4,  0, 1, 0,  4, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0,  1, 0, 0,  9, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,  0, 0, 0,  9, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,  1, 1, 0,  0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0,  1, 0, 0,  9, 1, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0,  1, 1, 0,  9, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 1, 9,  1, 1, 0,  9, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0,  1, 1, 1,  9, 0, 0, 1, 1};
        tbl[14] = '{0, 0, 0, 0,  0, 1, 1,  9, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 1, 3,  0, 1, 1,  3, 0, 0, 0, 0};

        #2;
        for (int i = 0; i < 16; i++) begin
            drive_a(tbl[i].rst, tbl[i].nset, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].sat);
            step();
            chk($sformatf("tbl%0d.S", i),    int'(bus_a.S),    tbl[i].s);
            chk($sformatf("tbl%0d.wrap", i), int'(bus_a.wrap), int'(tbl[i].w));
            chk($sformatf("tbl%0d.laps", i), int'(bus_a.laps), tbl[i].laps);
            chk($sformatf("tbl%0d.ovf", i),  int'(bus_a.ovf),  int'(tbl[i].ovf));
            chk($sformatf("tbl%0d.tc", i),   int'(bus_a.tc),   int'(tbl[i].tc));
        end

        // 12 up-steps from reset: wraps exactly once, on the 10th edge.
        drive_a(1, 0, 0, 0, 0, 1, 0); step();
        for (int i = 1; i <= 12; i++) begin
            drive_a(0, 0, 0, 0, 1, 1, 0); step();
            chk("up12.S", int'(bus_a.S), i % 10);
            chk("up12.wrap", int'(bus_a.wrap), (i == 10) ? 1 : 0);
        end
        chk("up12.laps", int'(bus_a.laps), 1);

        // Down-wrap decrements laps from 3 to 2.
        drive_a(1, 0, 0, 0, 0, 1, 0); step();
        for (int i = 0; i < 30; i++) begin drive_a(0, 0, 0, 0, 1, 1, 0); step(); end
        chk("dn.laps3", int'(bus_a.laps), 3);
        drive_a(0, 0, 0, 0, 1, 0, 0); step();
        chk("dn.S", int'(bus_a.S), 9);
        chk("dn.wrap", int'(bus_a.wrap), 1);
        chk("dn.laps", int'(bus_a.laps), 2);

        // Saturating up-count sticks at 9 with ovf from the 10th edge.
        drive_a(1, 0, 0, 0, 0, 1, 1); step();
        for (int i = 1; i <= 11; i++) begin
            drive_a(0, 0, 0, 0, 1, 1, 1); step();
            chk("sat.S", int'(bus_a.S), (i < 9) ? i : 9);
            chk("sat.ovf", int'(bus_a.ovf), (i >= 10) ? 1 : 0);
            chk("sat.wrap", int'(bus_a.wrap), 0);
        end
        drive_a(0, 0, 1, 3, 0, 1, 1); step();
        chk("sat.load.S", int'(bus_a.S), 3);
        chk("sat.load.ovf", int'(bus_a.ovf), 0);

        // LAP_W=2: laps saturates at 3; reset mid-lap clears everything.
        step();
        rst_b = 0; bus_b.en = 1;
        for (int i = 1; i <= 56; i++) begin
            step();
            if (i % 10 == 0) begin
                chk("l2.laps", int'(bus_b.laps), (i / 10 < 3) ? i / 10 : 3);
                chk("l2.wrap", int'(bus_b.wrap), 1);
            end
        end
        chk("l2.S6", int'(bus_b.S), 6);
        rst_b = 1; step();
        chk("l2.rst.S", int'(bus_b.S), 0);
        chk("l2.rst.laps", int'(bus_b.laps), 0);
        chk("l2.rst.wrap", int'(bus_b.wrap), 0);

        // Cascade: 100 low steps, then one more edge to let the carry land.
        rst_c = 0; bus_lo.en = 1; hi_wraps = 0;
        for (int i = 1; i <= 101; i++) begin
            if (i == 101) bus_lo.en = 0;
            step();
            if (bus_hi.wrap) hi_wraps++;
            if (i == 100) chk("casc.lo.S", int'(bus_lo.S), 0);
        end
        chk("casc.hi.S", int'(bus_hi.S), 0);
        chk("casc.hi.wraps", hi_wraps, 1);
        chk("casc.hi.laps", int'(bus_hi.laps), 1);
        chk("casc.lo.laps", int'(bus_lo.laps), 10);

        // MODULO = 2^BUS_SIZE: 15 -> 0 wraps up, 0 -> 15 wraps down.
        rst_d = 0; bus_d.load = 1; bus_d.load_val = 15; step();
        chk("m16.S15", int'(bus_d.S), 15);
        chk("m16.tc", int'(bus_d.tc), 1);
        bus_d.load = 0; bus_d.en = 1; step();
        chk("m16.up.S", int'(bus_d.S), 0);
        chk("m16.up.wrap", int'(bus_d.wrap), 1);
        bus_d.up = 0; step();
        chk("m16.dn.S", int'(bus_d.S), 15);
        chk("m16.dn.wrap", int'(bus_d.wrap), 1);
        chk("m16.dn.laps", int'(bus_d.laps), 0);

        // Random stimulus against the model.
        drive_a(1, 0, 0, 0, 0, 1, 0); step();
        m_s = 0; m_laps = 0; m_wrap = 0; m_ovf = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, ns, ld, en, up, sat;
            int lv;
            r   = ($urandom_range(49) == 0);
            ns  = ($urandom_range(19) == 0);
            ld  = ($urandom_range(9) == 0);
            lv  = int'($urandom_range(15));
            en  = ($urandom_range(3) != 0);
            up  = ($urandom_range(2) != 0);
            sat = ($urandom_range(3) == 0);
            drive_a(r, ns, ld, lv, en, up, sat);
            model(r, ns, ld, lv, en, up, sat);
            step();
            chk("rnd.S", int'(bus_a.S), m_s);
            chk("rnd.wrap", int'(bus_a.wrap), m_wrap);
            chk("rnd.laps", int'(bus_a.laps), m_laps);
            chk("rnd.ovf", int'(bus_a.ovf), m_ovf);
            chk("rnd.tc", int'(bus_a.tc), (up ? (m_s == 9) : (m_s == 0)) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
